// File: rtl/parking_pkg.sv
// Shared types and width helpers for the parking entry controller.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_PIN = 2'd1,
    OPEN     = 2'd2,
    BLOCK    = 2'd3
  } state_t;

  // Bits needed to hold any value in 0..max_val (never less than one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int tmr_w(input int gate_to);
    return cnt_w(gate_to - 1);
  endfunction

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Driver-side and controller-side signal bundle for the parking entry gate.
interface parking_gate_ctrl_if
  import parking_pkg::*;
#(
  parameter int PIN_W    = 8,
  parameter int CAPACITY = 16
);
  logic                       sensor_1;
  logic                       sensor_2;
  logic                       try_pin;
  logic [PIN_W-1:0]           pin_in;
  logic                       car_exit;
  logic                       alarm_pin;
  logic                       alarm_block;
  logic                       open_gate;
  logic                       close_gate;
  logic                       lot_full;
  logic [cnt_w(CAPACITY)-1:0] occupancy;

  modport master (
    output sensor_1, sensor_2, try_pin, pin_in, car_exit,
    input  alarm_pin, alarm_block, open_gate, close_gate, lot_full, occupancy
  );

  modport slave (
    input  sensor_1, sensor_2, try_pin, pin_in, car_exit,
    output alarm_pin, alarm_block, open_gate, close_gate, lot_full, occupancy
  );
endinterface

// File: rtl/parking_occupancy_cnt.sv
// Saturating up/down lot-occupancy counter; full is registered from the next count.
module parking_occupancy_cnt
  import parking_pkg::*;
#(
  parameter int CAPACITY = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inc,
  input  logic                       dec,
  output logic [cnt_w(CAPACITY)-1:0] count,
  output logic                       full
);
  localparam int CNT_W = cnt_w(CAPACITY);

  logic [CNT_W-1:0] count_n;

  function automatic logic [CNT_W-1:0] sat_up(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(CAPACITY)) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_down(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

  // An entry and an exit in the same cycle cancel out.
  always_comb begin
    count_n = count;
    case ({inc, dec})
      2'b10:   count_n = sat_up(count);
      2'b01:   count_n = sat_down(count);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      full  <= 1'b0;
    end else begin
      count <= count_n;
      full  <= (count_n == CNT_W'(CAPACITY));
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking entry controller: PIN check with retry alarm, tamper block, gate timeout and lot occupancy.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int               PIN_W     = 8,
  parameter logic [PIN_W-1:0] PIN_VAL   = PIN_W'(87),
  parameter int               MAX_TRIES = 3,
  parameter int               CAPACITY  = 16,
  parameter int               GATE_TO   = 1000
) (
  input logic                clk,
  input logic                rst,
  parking_gate_ctrl_if.slave bus
);
  localparam int FAIL_W = cnt_w(MAX_TRIES);
  localparam int TMR_W  = tmr_w(GATE_TO);
  localparam int OCC_W  = cnt_w(CAPACITY);

  state_t            state, state_n;
  logic [FAIL_W-1:0] fail_cnt, fail_n;
  logic [TMR_W-1:0]  timer, timer_n;
  logic              open_r, open_n;
  logic              close_r, close_n;
  logic              apin_r, apin_n;
  logic              ablk_r, ablk_n;
  logic              entry;
  logic              pin_ok;
  logic              full;
  logic [OCC_W-1:0]  occ;

  function automatic logic [FAIL_W-1:0] sat_inc_fail(input logic [FAIL_W-1:0] v);
    return (v >= FAIL_W'(MAX_TRIES)) ? v : v + FAIL_W'(1);
  endfunction

  assign pin_ok = (bus.pin_in == PIN_VAL);

  always_comb begin
    state_n = state;
    fail_n  = fail_cnt;
    timer_n = timer;
    open_n  = open_r;
    close_n = 1'b0;
    apin_n  = apin_r;
    ablk_n  = ablk_r;
    entry   = 1'b0;
    // Both sensors at once means someone is forcing the gate.
    if (state != BLOCK && bus.sensor_1 && bus.sensor_2) begin
      state_n = BLOCK;
      ablk_n  = 1'b1;
      open_n  = 1'b0;
      apin_n  = 1'b0;
      fail_n  = '0;
      timer_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          open_n = 1'b0;
          apin_n = 1'b0;
          if (bus.sensor_1 && !full) state_n = WAIT_PIN;
        end
        WAIT_PIN: begin
          if (bus.try_pin) begin
            if (pin_ok) begin
              open_n  = 1'b1;
              fail_n  = '0;
              apin_n  = 1'b0;
              timer_n = '0;
              state_n = OPEN;
            end else begin
              fail_n = sat_inc_fail(fail_cnt);
              apin_n = (fail_n == FAIL_W'(MAX_TRIES));
            end
          end else if (!bus.sensor_1) begin
            fail_n  = '0;
            apin_n  = 1'b0;
            state_n = IDLE;
          end
        end
        OPEN: begin
          if (bus.sensor_2) begin
            open_n  = 1'b0;
            close_n = 1'b1;
            entry   = 1'b1;
            state_n = IDLE;
          end else if (timer == TMR_W'(GATE_TO - 1)) begin
            open_n  = 1'b0;
            close_n = 1'b1;
            state_n = IDLE;
          end else begin
            timer_n = timer + TMR_W'(1);
          end
        end
        BLOCK: begin
          if (bus.try_pin && pin_ok) begin
            ablk_n  = 1'b0;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fail_cnt <= '0;
      timer    <= '0;
      open_r   <= 1'b0;
      close_r  <= 1'b0;
      apin_r   <= 1'b0;
      ablk_r   <= 1'b0;
    end else begin
      state    <= state_n;
      fail_cnt <= fail_n;
      timer    <= timer_n;
      open_r   <= open_n;
      close_r  <= close_n;
      apin_r   <= apin_n;
      ablk_r   <= ablk_n;
    end
  end

  parking_occupancy_cnt #(
    .CAPACITY(CAPACITY)
  ) u_occ (
    .clk  (clk),
    .rst  (rst),
    .inc  (entry),
    .dec  (bus.car_exit),
    .count(occ),
    .full (full)
  );

  assign bus.open_gate   = open_r;
  assign bus.close_gate  = close_r;
  assign bus.alarm_pin   = apin_r;
  assign bus.alarm_block = ablk_r;
  assign bus.lot_full    = full;
  assign bus.occupancy   = occ;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed plus randomized bench for parking_gate_ctrl against a behavioural lot/gate model.
module tb_parking_gate_ctrl;
  localparam int PIN_W = 8;
  localparam int PV    = 87;
  localparam int MT    = 3;
  localparam int CAP   = 2;
  localparam int GTO   = 4;

  localparam int M_IDLE = 0, M_WAIT = 1, M_OPEN = 2, M_BLOCK = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parking_gate_ctrl_if #(.PIN_W(PIN_W), .CAPACITY(CAP)) bus ();

  parking_gate_ctrl #(
    .PIN_W    (PIN_W),
    .PIN_VAL  (8'd87),
    .MAX_TRIES(MT),
    .CAPACITY (CAP),
    .GATE_TO  (GTO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int m_mode, m_tries, m_waited, m_occ;
  bit m_open, m_close, m_apin, m_ablk, m_full;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_tries = 0; m_waited = 0; m_occ = 0;
    m_open = 0; m_close = 0; m_apin = 0; m_ablk = 0; m_full = 0;
  endtask

  // One clock of the lot as a driver/guard would describe it.
  task automatic model_step();
    bit s1, s2, tp, ex, good, parked;
    s1 = bus.sensor_1; s2 = bus.sensor_2; tp = bus.try_pin; ex = bus.car_exit;
    good = (int'(bus.pin_in) == PV);
    parked = 0;
    m_close = 0;
    if (m_mode != M_BLOCK && s1 && s2) begin
      m_mode = M_BLOCK; m_ablk = 1; m_open = 0; m_apin = 0; m_tries = 0;
    end else if (m_mode == M_IDLE) begin
      if (s1 && !m_full) m_mode = M_WAIT;
    end else if (m_mode == M_WAIT) begin
      if (tp && good) begin
        m_mode = M_OPEN; m_open = 1; m_tries = 0; m_apin = 0; m_waited = 0;
      end else if (tp) begin
        m_tries = (m_tries + 1 > MT) ? MT : m_tries + 1;
        if (m_tries == MT) m_apin = 1;
      end else if (!s1) begin
        m_mode = M_IDLE; m_tries = 0; m_apin = 0;
      end
    end else if (m_mode == M_OPEN) begin
      if (s2) begin
        parked = 1; m_open = 0; m_close = 1; m_mode = M_IDLE;
      end else if (m_waited == GTO - 1) begin
        m_open = 0; m_close = 1; m_mode = M_IDLE;
      end else begin
        m_waited++;
      end
    end else begin
      if (tp && good) begin
        m_ablk = 0; m_mode = M_IDLE;
      end
    end
    m_occ = m_occ + int'(parked) - int'(ex);
    if (m_occ < 0) m_occ = 0;
    if (m_occ > CAP) m_occ = CAP;
    m_full = (m_occ == CAP);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".open"},  bus.open_gate,   m_open);
    check({tag, ".close"}, bus.close_gate,  m_close);
    check({tag, ".apin"},  bus.alarm_pin,   m_apin);
    check({tag, ".ablk"},  bus.alarm_block, m_ablk);
    check({tag, ".full"},  bus.lot_full,    m_full);
    check({tag, ".occ"},   32'(bus.occupancy), m_occ);
  endtask

  task automatic step(input bit s1, input bit s2, input bit tp, input int pin, input bit ex,
                      input string tag);
    bus.sensor_1 = s1;
    bus.sensor_2 = s2;
    bus.try_pin  = tp;
    bus.pin_in   = PIN_W'(pin);
    bus.car_exit = ex;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.sensor_1 = 0; bus.sensor_2 = 0; bus.try_pin = 0; bus.pin_in = '0; bus.car_exit = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset.occ_lit", 32'(bus.occupancy), 0);
    rst = 1'b0;

    // Happy path
    step(1, 0, 0, 0, 0, "happy.arrive");
    step(1, 0, 1, PV, 0, "happy.pin");
    check("happy.open_lit", bus.open_gate, 1);
    step(0, 1, 0, 0, 0, "happy.pass");
    check("happy.close_lit", bus.close_gate, 1);
    check("happy.occ_lit", 32'(bus.occupancy), 1);
    step(0, 0, 0, 0, 0, "happy.after");
    check("happy.pulse_lit", bus.close_gate, 0);

    // Retry limit
    step(1, 0, 0, 0, 0, "retry.arrive");
    step(1, 0, 1, 5, 0, "retry.w1");
    step(1, 0, 1, 6, 0, "retry.w2");
    check("retry.apin_before_lit", bus.alarm_pin, 0);
    step(1, 0, 1, 7, 0, "retry.w3");
    check("retry.apin_lit", bus.alarm_pin, 1);
    step(1, 0, 1, PV, 0, "retry.good");
    check("retry.open_lit", bus.open_gate, 1);
    check("retry.apin_clr_lit", bus.alarm_pin, 0);
    step(0, 1, 0, 0, 0, "retry.pass");
    check("full.flag_lit", bus.lot_full, 1);

    // Full lot ignores arrivals and PINs
    step(1, 0, 0, 0, 0, "full.arrive");
    step(1, 0, 1, PV, 0, "full.pin");
    check("full.no_open_lit", bus.open_gate, 0);
    step(0, 0, 0, 0, 1, "full.exit");
    check("full.exit_occ_lit", 32'(bus.occupancy), 1);
    check("full.exit_flag_lit", bus.lot_full, 0);

    // Tamper block
    step(1, 0, 0, 0, 0, "blk.arrive");
    step(1, 0, 1, PV, 0, "blk.pin");
    step(1, 1, 0, 0, 0, "blk.both");
    check("blk.ablk_lit", bus.alarm_block, 1);
    check("blk.open_lit", bus.open_gate, 0);
    step(0, 0, 1, 5, 0, "blk.wrong");
    step(1, 0, 0, 0, 0, "blk.sensor");
    check("blk.hold_lit", bus.alarm_block, 1);
    step(0, 0, 1, PV, 0, "blk.good");
    check("blk.clear_lit", bus.alarm_block, 0);

    // Gate-open timeout
    step(1, 0, 0, 0, 0, "to.arrive");
    step(1, 0, 1, PV, 0, "to.pin");
    for (int i = 0; i < GTO - 1; i++) begin
      step(0, 0, 0, 0, 0, "to.wait");
      check("to.still_open_lit", bus.open_gate, 1);
    end
    step(0, 0, 0, 0, 0, "to.expire");
    check("to.close_lit", bus.close_gate, 1);
    check("to.occ_lit", 32'(bus.occupancy), 1);

    // Occupancy corners
    step(0, 0, 0, 0, 1, "occ.exit1");
    step(0, 0, 0, 0, 1, "occ.exit0");
    check("occ.floor_lit", 32'(bus.occupancy), 0);
    step(1, 0, 0, 0, 0, "occ.a1");
    step(1, 0, 1, PV, 0, "occ.p1");
    step(0, 1, 0, 0, 0, "occ.in1");
    step(1, 0, 0, 0, 0, "occ.a2");
    step(1, 0, 1, PV, 0, "occ.p2");
    step(0, 1, 0, 0, 1, "occ.inout");
    check("occ.cancel_lit", 32'(bus.occupancy), 1);

    // Asynchronous reset while the gate is open
    step(1, 0, 0, 0, 0, "ar.arrive");
    step(1, 0, 1, PV, 0, "ar.pin");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("ar.async");
    check("ar.open_lit", bus.open_gate, 0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit s1, s2, tp, ex;
      int pin;
      s1  = ($urandom % 3) != 0;
      s2  = ($urandom % 4) == 0;
      tp  = ($urandom % 2) == 0;
      pin = (($urandom % 5) < 2) ? PV : int'($urandom % 256);
      ex  = ($urandom % 6) == 0;
      step(s1, s2, tp, pin, ex, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
